// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a four-opcode toy CPU: owns pc and ir and
// derives the datapath controls combinationally from the registered state.
module cpu_sequencer #(
  parameter int PROG_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instr_in,
  input  logic       alu_zero,
  input  logic       dmem_ready,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic [1:0] rs,
  output logic [1:0] rt,
  output logic [1:0] rd,
  output logic [7:0] imm,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic [2:0] state,
  output logic       halted
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_BEQ = 2'b11
  } op_t;

  // Nine bits so that PROG_LEN = 256 never halts an 8-bit pc.
  localparam logic [8:0] PROG_END = 9'(PROG_LEN);

  state_t     state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] ir_reg, ir_next;
  op_t        op;
  logic       is_mem_op;

  assign op        = op_t'(ir_reg[7:6]);
  assign is_mem_op = (op == OP_LW) || (op == OP_SW);

  assign pc    = pc_reg;
  assign ir    = ir_reg;
  assign rs    = ir_reg[5:4];
  assign rt    = ir_reg[3:2];
  assign rd    = ir_reg[1:0];
  assign imm   = {{6{ir_reg[1]}}, ir_reg[1:0]};
  assign state = state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= 8'd0;
      ir_reg    <= 8'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if ({1'b0, pc_reg} >= PROG_END) begin
          state_next = S_HALT;
        end else begin
          ir_next    = instr_in;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        pc_next    = pc_reg + 8'd1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        alu_src = is_mem_op;
        case (op)
          OP_ADD: state_next = S_WB;
          OP_LW,
          OP_SW:  state_next = S_MEM;
          OP_BEQ: begin
            // pc already points past the branch, so this yields pc+1+imm.
            if (alu_zero) pc_next = pc_reg + imm;
            state_next = S_FETCH;
          end
          default: state_next = S_IDLE;
        endcase
      end
      S_MEM: begin
        alu_src   = is_mem_op;
        mem_read  = (op == OP_LW);
        mem_write = (op == OP_SW);
        if (dmem_ready) state_next = (op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) begin
          pc_next    = 8'd0;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboarded bench: stimulus queues the expected FETCH/HALT boundary events
// and a negedge monitor pops and compares them as the sequencer reaches each.
module tb_cpu_sequencer;
  localparam int PL = 32;

  logic       clk = 1'b0;
  logic       rst, run, alu_zero, dmem_ready;
  logic [7:0] instr_in, pc, ir, imm;
  logic [1:0] rs, rt, rd;
  logic       reg_write, mem_read, mem_write, alu_src, halted;
  logic [2:0] state;

  logic       run4;
  logic [7:0] pc4, ir4, imm4;
  logic [1:0] rs4, rt4, rd4;
  logic       rw4, mr4, mw4, as4, halted4;
  logic [2:0] state4;

  logic [7:0] rom [256];
  int         waits [256];
  logic       zero_tab [256];

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_halt;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] imm;
    int         lat;
    int         rw;
    int         mr;
    int         mw;
    int         asn;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  assign instr_in = rom[pc];

  cpu_sequencer #(.PROG_LEN(PL)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .alu_zero(alu_zero),
    .dmem_ready(dmem_ready), .pc(pc), .ir(ir), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .state(state), .halted(halted)
  );

  cpu_sequencer #(.PROG_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .run(run4), .instr_in(8'h00), .alu_zero(1'b0),
    .dmem_ready(1'b0), .pc(pc4), .ir(ir4), .rs(rs4), .rt(rt4), .rd(rd4), .imm(imm4),
    .reg_write(rw4), .mem_read(mr4), .mem_write(mw4),
    .alu_src(as4), .state(state4), .halted(halted4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_f(input logic [7:0] p, input int lat, input logic [7:0] i,
                                 input logic [7:0] im, input int rw, input int mr,
                                 input int mw, input int asn);
    ev_t e;
    e.is_halt = 1'b0; e.pc = p; e.ir = i; e.imm = im; e.lat = lat;
    e.rw = rw; e.mr = mr; e.mw = mw; e.asn = asn;
    exp_q.push_back(e);
  endfunction

  function automatic void push_h(input logic [7:0] p, input logic [7:0] i);
    ev_t e;
    e.is_halt = 1'b1; e.pc = p; e.ir = i; e.imm = 8'h00; e.lat = -1;
    e.rw = 0; e.mr = 0; e.mw = 0; e.asn = 0;
    exp_q.push_back(e);
  endfunction

  // Memory / comparator model: answers dmem_ready and alu_zero for the
  // instruction at pc-1 (pc has already advanced past it in DECODE).
  int         mem_cnt;
  logic [7:0] drv_a;
  always @(negedge clk) begin
    drv_a = pc - 8'd1;
    if (state == 3'd4) begin
      dmem_ready = (mem_cnt >= waits[drv_a]);
      mem_cnt++;
    end else begin
      dmem_ready = 1'($urandom_range(0, 1));
      mem_cnt = 0;
    end
    alu_zero = (state == 3'd3) ? zero_tab[drv_a] : 1'($urandom_range(0, 1));
  end

  // Monitor: per-cycle control invariants plus boundary-event scoreboard.
  int         cyc_since, rw_cnt, mr_cnt, mw_cnt, as_cnt;
  logic [2:0] prev_state;
  ev_t        ev;
  always @(negedge clk) begin
    if (rst) begin
      prev_state = 3'd0;
      cyc_since = 0; rw_cnt = 0; mr_cnt = 0; mw_cnt = 0; as_cnt = 0;
    end else begin
      cyc_since++;
      rw_cnt += int'(reg_write);
      mr_cnt += int'(mem_read);
      mw_cnt += int'(mem_write);
      as_cnt += int'(alu_src);
      chk("mem_exclusive", 32'(mem_read & mem_write), 32'd0);
      chk("reg_write_outside_wb", 32'(reg_write & (state != 3'd5)), 32'd0);
      chk("mem_ctrl_outside_mem", 32'((mem_read | mem_write) & (state != 3'd4)), 32'd0);
      chk("halted_vs_state", 32'(halted), 32'(state == 3'd6));
      if (state == 3'd1 || (state == 3'd6 && prev_state != 3'd6)) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event state=%0d pc=%0h required=none", state, pc);
        end else begin
          ev = exp_q.pop_front();
          chk("event_state", 32'(state), ev.is_halt ? 32'd6 : 32'd1);
          chk("event_pc", 32'(pc), 32'(ev.pc));
          chk("event_ir", 32'(ir), 32'(ev.ir));
          if (ev.is_halt) chk("event_halted", 32'(halted), 32'd1);
          else            chk("event_imm", 32'(imm), 32'(ev.imm));
          if (ev.lat >= 0) begin
            chk("latency", 32'(cyc_since), 32'(ev.lat));
            chk("reg_write_cycles", 32'(rw_cnt), 32'(ev.rw));
            chk("mem_read_cycles", 32'(mr_cnt), 32'(ev.mr));
            chk("mem_write_cycles", 32'(mw_cnt), 32'(ev.mw));
            chk("alu_src_cycles", 32'(as_cnt), 32'(ev.asn));
          end
        end
        if (state == 3'd1) begin
          cyc_since = 0; rw_cnt = 0; mr_cnt = 0; mw_cnt = 0; as_cnt = 0;
        end
      end
      prev_state = state;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00; waits[i] = 0; zero_tab[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; run4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (state == s) break;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  // Instruction-level reference for the randomised programs.
  task automatic model_run();
    logic [7:0] pcm, irm, im, npc;
    int w;
    pcm = 8'd0; irm = 8'd0;
    push_f(pcm, -1, irm, 8'h00, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      if (int'(pcm) >= PL) begin
        push_h(pcm, irm);
        break;
      end
      irm = rom[pcm];
      im  = {{6{irm[1]}}, irm[1:0]};
      npc = pcm + 8'd1;
      w   = waits[pcm];
      case (irm[7:6])
        2'b00: push_f(npc, 4, irm, im, 1, 0, 0, 0);
        2'b01: push_f(npc, 5 + w, irm, im, 1, w + 1, 0, w + 2);
        2'b10: push_f(npc, 4 + w, irm, im, 0, 0, w + 1, w + 2);
        default: begin
          if (zero_tab[pcm]) npc = npc + im;
          push_f(npc, 3, irm, im, 0, 0, 0, 0);
        end
      endcase
      pcm = npc;
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; run = 1'b0; run4 = 1'b0;
    clear_mem();

    // ADD at pc 0; run held through FETCH..EXEC must be ignored.
    do_reset();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_ir", 32'(ir), 32'd0);
    chk("reset_ctrl", 32'({reg_write, mem_read, mem_write, alu_src, halted}), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_without_run", 32'(state), 32'd0);
    rom[0] = 8'h1B;
    push_f(8'd0, -1, 8'h00, 8'h00, 0, 0, 0, 0);
    push_f(8'd1, 4, 8'h1B, 8'hFF, 1, 0, 0, 0);
    @(negedge clk) run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    wait_state(3'd5, "add_reach_wb");
    chk("add_fields", 32'({rs, rt, rd}), 32'({2'd1, 2'd2, 2'd3}));
    chk("add_reg_write", 32'(reg_write), 32'd1);
    drain(50);

    // LW with three wait states.
    do_reset(); clear_mem();
    rom[0] = 8'h47; waits[0] = 3;
    push_f(8'd0, -1, 8'h00, 8'h00, 0, 0, 0, 0);
    push_f(8'd1, 8, 8'h47, 8'hFF, 1, 4, 0, 5);
    pulse_run();
    wait_state(3'd4, "lw_reach_mem");
    chk("lw_mem_ctrl", 32'({mem_read, mem_write, alu_src}), 32'b101);
    chk("lw_imm", 32'(imm), 32'hFF);
    drain(50);

    // BEQ at pc 5, taken then not taken.
    for (int t = 1; t >= 0; t--) begin
      do_reset(); clear_mem();
      rom[5] = 8'hC6; zero_tab[5] = 1'(t);
      push_f(8'd0, -1, 8'h00, 8'h00, 0, 0, 0, 0);
      for (int a = 1; a <= 5; a++) push_f(8'(a), 4, 8'h00, 8'h00, 1, 0, 0, 0);
      push_f(t ? 8'd4 : 8'd6, 3, 8'hC6, 8'hFE, 0, 0, 0, 0);
      pulse_run();
      drain(100);
    end

    // Branch target wraps to 255, halts, restarts from HALT twice.
    do_reset(); clear_mem();
    rom[0] = 8'hC2; zero_tab[0] = 1'b1;
    push_f(8'd0, -1, 8'h00, 8'h00, 0, 0, 0, 0);
    push_f(8'd255, 3, 8'hC2, 8'hFE, 0, 0, 0, 0);
    push_h(8'd255, 8'hC2);
    pulse_run();
    drain(50);
    repeat (2) @(negedge clk);
    chk("halt_sticky", 32'({state, halted}), 32'({3'd6, 1'b1}));
    push_f(8'd0, -1, 8'hC2, 8'hFE, 0, 0, 0, 0);
    push_f(8'd255, 3, 8'hC2, 8'hFE, 0, 0, 0, 0);
    push_h(8'd255, 8'hC2);
    pulse_run();
    drain(50);

    // SW stalled in MEM, reset asserted between clock edges.
    do_reset(); clear_mem();
    rom[0] = 8'h84; waits[0] = 1000;
    push_f(8'd0, -1, 8'h00, 8'h00, 0, 0, 0, 0);
    pulse_run();
    wait_state(3'd4, "sw_reach_mem");
    chk("sw_mem_ctrl", 32'({mem_read, mem_write}), 32'b01);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async_rst_mem_write", 32'(mem_write), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'd0);
    chk("sw_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk) rst = 1'b0;

    // PROG_LEN=4 instance: four ADDs, then HALT at pc 4, then restart.
    do_reset();
    @(negedge clk) run4 = 1'b1;
    @(negedge clk) run4 = 1'b0;
    chk("p4_first_fetch", 32'(state4), 32'd1);
    cnt = 0;
    while (!halted4 && cnt < 100) begin
      @(negedge clk); cnt++;
    end
    chk("p4_halt_cycles", 32'(cnt), 32'd17);
    chk("p4_halt_pc", 32'({pc4, halted4, state4}), 32'({8'd4, 1'b1, 3'd6}));
    chk("p4_halt_outputs", 32'({ir4, imm4, rs4, rt4, rd4, rw4, mr4, mw4, as4}), 32'd0);
    @(negedge clk) run4 = 1'b1;
    @(negedge clk) run4 = 1'b0;
    chk("p4_restart", 32'({pc4, halted4, state4}), 32'({8'd0, 1'b0, 3'd1}));

    // Random programs with random wait states; every BEQ that could loop back
    // is forced not-taken so each program runs into pc >= PROG_LEN.
    for (int r = 0; r < 3; r++) begin
      do_reset(); clear_mem();
      for (int a = 0; a < 256; a++) begin
        rom[a]      = 8'($urandom);
        waits[a]    = int'($urandom_range(0, 3));
        zero_tab[a] = rom[a][1] ? 1'b0 : 1'($urandom_range(0, 1));
      end
      model_run();
      pulse_run();
      drain(3000);
    end

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
